// File: rtl/nco_frequency_estimator_pkg.sv
// nco_est_pkg: shared definitions for the NCO frequency estimator.
//   - est_state_t     : estimator FSM states
//   - ATAN_TABLE      : atan(2^-i) in turns, 32-bit scale (full turn = 2^32)
//   - atan_turns()    : table entry rescaled to a narrower phase width
//   - CORDIC_GAIN_Q16 : 1/K of the vectoring CORDIC in Q0.16, for callers
//                       that want the vector magnitude from the x path
package nco_est_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_ACCUM = 2'd2
  } est_state_t;

  localparam int ATAN_ENTRIES = 32;

  localparam logic [31:0] ATAN_TABLE [ATAN_ENTRIES] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
    32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
  };

  // 1/1.646760 = 0.607253 -> 0x9B75 in Q0.16
  localparam logic [15:0] CORDIC_GAIN_Q16 = 16'h9B75;

  // Phase widths up to 32 bits: drop the low bits of the 32-bit table.
  function automatic logic [31:0] atan_turns(input int stage, input int pw);
    return ATAN_TABLE[stage] >> (32 - pw);
  endfunction

endpackage

// File: rtl/nco_frequency_estimator_if.sv
// nco_frequency_estimator_if: sample stream in, phase/frequency results out.
//   sine_in/cosine_in/valid_in : quadrature sample stream into the estimator
//   phase_out/phase_valid      : per-sample instantaneous phase
//   freq_word_out/freq_valid   : averaged frequency estimate, one-cycle pulse
//   locked                     : consecutive estimates agree
// Handshake: every stream here is valid-only. A beat transfers on each clock
// edge where its valid is high; there is no ready and no backpressure, so
// the consumer must accept every qualified beat.
// master = sample source / result sink, slave = estimator.
interface nco_frequency_estimator_if #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int PHASE_WIDTH  = 32
);
  logic signed [SAMPLE_WIDTH-1:0] sine_in;
  logic signed [SAMPLE_WIDTH-1:0] cosine_in;
  logic                           valid_in;
  logic [PHASE_WIDTH-1:0]         phase_out;
  logic                           phase_valid;
  logic [PHASE_WIDTH-1:0]         freq_word_out;
  logic                           freq_valid;
  logic                           locked;

  modport master (
    output sine_in, cosine_in, valid_in,
    input  phase_out, phase_valid, freq_word_out, freq_valid, locked
  );

  modport slave (
    input  sine_in, cosine_in, valid_in,
    output phase_out, phase_valid, freq_word_out, freq_valid, locked
  );
endinterface

// File: rtl/nco_frequency_estimator_cordic.sv
// cordic_vectoring: pipelined vectoring-mode CORDIC returning atan2(sine, cosine)
// as unsigned turns (full turn = 2^PHASE_WIDTH).
//   clk, rst               : clock, synchronous active-high reset
//   sine_in, cosine_in     : signed Q/I samples
//   valid_in               : sample qualifier
//   phase_out, phase_valid : phase, CORDIC_STAGES+1 cycles after valid_in
// The pipeline advances every cycle; the valid bit simply rides with the data.
module cordic_vectoring
  import nco_est_pkg::*;
#(
  parameter int SAMPLE_WIDTH  = 16,
  parameter int PHASE_WIDTH   = 32,
  parameter int CORDIC_STAGES = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [SAMPLE_WIDTH-1:0] sine_in,
  input  logic signed [SAMPLE_WIDTH-1:0] cosine_in,
  input  logic                           valid_in,
  output logic [PHASE_WIDTH-1:0]         phase_out,
  output logic                           phase_valid
);
  // Two guard bits: one so -2^(SW-1) can be negated, one for CORDIC gain.
  localparam int XW = SAMPLE_WIDTH + 2;

  logic signed [XW-1:0]   x_q    [0:CORDIC_STAGES];
  logic signed [XW-1:0]   y_q    [0:CORDIC_STAGES];
  logic [PHASE_WIDTH-1:0] z_q    [0:CORDIC_STAGES];
  logic                   v_q    [0:CORDIC_STAGES];
  logic                   zero_q [0:CORDIC_STAGES];

  logic signed [XW-1:0] sin_ext;
  logic signed [XW-1:0] cos_ext;

  assign sin_ext = {{2{sine_in[SAMPLE_WIDTH-1]}}, sine_in};
  assign cos_ext = {{2{cosine_in[SAMPLE_WIDTH-1]}}, cosine_in};

  function automatic logic [PHASE_WIDTH-1:0] atan_w(input int stage);
    logic [31:0] t;
    t = atan_turns(stage, PHASE_WIDTH);
    return t[PHASE_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= CORDIC_STAGES; i++) begin
        x_q[i]    <= '0;
        y_q[i]    <= '0;
        z_q[i]    <= '0;
        v_q[i]    <= 1'b0;
        zero_q[i] <= 1'b0;
      end
    end else begin
      // Pre-rotation into the right half-plane so the stages only need +-90 deg.
      v_q[0]    <= valid_in;
      // A (0,0) vector has no angle; it is forced to phase 0 at the output.
      zero_q[0] <= (sine_in == '0) && (cosine_in == '0);
      if (cos_ext < 0) begin
        x_q[0] <= -cos_ext;
        y_q[0] <= -sin_ext;
        z_q[0] <= {1'b1, {(PHASE_WIDTH-1){1'b0}}};
      end else begin
        x_q[0] <= cos_ext;
        y_q[0] <= sin_ext;
        z_q[0] <= '0;
      end

      // Each stage rotates toward y = 0 and books the rotation into z.
      for (int i = 0; i < CORDIC_STAGES; i++) begin
        v_q[i+1]    <= v_q[i];
        zero_q[i+1] <= zero_q[i];
        if (y_q[i] < 0) begin
          x_q[i+1] <= x_q[i] - (y_q[i] >>> i);
          y_q[i+1] <= y_q[i] + (x_q[i] >>> i);
          z_q[i+1] <= z_q[i] - atan_w(i);
        end else begin
          x_q[i+1] <= x_q[i] + (y_q[i] >>> i);
          y_q[i+1] <= y_q[i] - (x_q[i] >>> i);
          z_q[i+1] <= z_q[i] + atan_w(i);
        end
      end
    end
  end

  assign phase_out   = zero_q[CORDIC_STAGES] ? '0 : z_q[CORDIC_STAGES];
  assign phase_valid = v_q[CORDIC_STAGES];

endmodule

// File: rtl/nco_frequency_estimator.sv
// nco_frequency_estimator: recovers the NCO frequency word from a quadrature
// sample stream. CORDIC phase -> phase differences -> average of 2^AVG_LOG2
// differences per estimate, windows back-to-back.
//   clk, rst  : clock, synchronous active-high reset
//   enable    : run; low sends the FSM to S_IDLE (estimate and lock held)
//   clear     : one-cycle pulse, restarts the current averaging window
//   bus       : sample stream in, phase/frequency/lock out (slave modport)
//   state_dbg : current FSM state
module nco_frequency_estimator
  import nco_est_pkg::*;
#(
  parameter int                     SAMPLE_WIDTH  = 16,
  parameter int                     PHASE_WIDTH   = 32,
  parameter int                     CORDIC_STAGES = 16,
  parameter int                     AVG_LOG2      = 8,
  parameter logic [PHASE_WIDTH-1:0] LOCK_TOL      = PHASE_WIDTH'(32'h0000_0400)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          clear,
  nco_frequency_estimator_if.slave      bus,
  output est_state_t                    state_dbg
);
  localparam int                ACC_W      = PHASE_WIDTH + AVG_LOG2;
  localparam logic [AVG_LOG2-1:0] COUNT_LAST = '1;

  logic [PHASE_WIDTH-1:0] phase_w;
  logic                   pv_w;

  cordic_vectoring #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .PHASE_WIDTH  (PHASE_WIDTH),
    .CORDIC_STAGES(CORDIC_STAGES)
  ) u_cordic (
    .clk        (clk),
    .rst        (rst),
    .sine_in    (bus.sine_in),
    .cosine_in  (bus.cosine_in),
    .valid_in   (bus.valid_in),
    .phase_out  (phase_w),
    .phase_valid(pv_w)
  );

  est_state_t              state, state_n;
  logic [PHASE_WIDTH-1:0]  prev_phase;
  logic signed [ACC_W-1:0] acc;
  logic [AVG_LOG2-1:0]     count;
  logic [PHASE_WIDTH-1:0]  freq_word_q;
  logic                    freq_valid_q;
  logic                    locked_q;
  logic                    have_est;   // an estimate exists since leaving S_IDLE

  logic do_restart, do_prime, do_accum, do_final, do_clear;

  // Delta wraps naturally modulo a full turn and is read as signed.
  logic [PHASE_WIDTH-1:0]  delta;
  logic signed [ACC_W-1:0] delta_ext;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] acc_shr;
  logic [PHASE_WIDTH-1:0]  new_est;
  logic [PHASE_WIDTH-1:0]  est_diff;
  logic [PHASE_WIDTH-1:0]  est_mag;
  logic                    within_tol;

  assign delta      = phase_w - prev_phase;
  assign delta_ext  = {{AVG_LOG2{delta[PHASE_WIDTH-1]}}, delta};
  assign acc_sum    = acc + delta_ext;
  assign acc_shr    = acc_sum >>> AVG_LOG2;
  assign new_est    = acc_shr[PHASE_WIDTH-1:0];
  assign est_diff   = new_est - freq_word_q;
  assign est_mag    = est_diff[PHASE_WIDTH-1] ? -est_diff : est_diff;
  assign within_tol = (est_mag <= LOCK_TOL);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    do_restart = 1'b0;
    do_prime   = 1'b0;
    do_accum   = 1'b0;
    do_final   = 1'b0;
    do_clear   = 1'b0;
    if (!enable) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          state_n    = S_PRIME;
          do_restart = 1'b1;
        end
        S_PRIME: begin
          if (pv_w) begin
            do_prime = 1'b1;
            state_n  = S_ACCUM;
          end
        end
        S_ACCUM: begin
          // clear beats a coincident final sample: that window is dropped.
          if (clear) begin
            do_clear = 1'b1;
            state_n  = S_PRIME;
          end else if (pv_w) begin
            if (count == COUNT_LAST) do_final = 1'b1;
            else                     do_accum = 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_phase   <= '0;
      acc          <= '0;
      count        <= '0;
      freq_word_q  <= '0;
      freq_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      have_est     <= 1'b0;
    end else begin
      freq_valid_q <= do_final;
      if (do_restart) begin
        locked_q <= 1'b0;
        have_est <= 1'b0;
      end
      if (do_clear) begin
        locked_q <= 1'b0;
        acc      <= '0;
        count    <= '0;
      end
      if (do_prime) begin
        prev_phase <= phase_w;
        acc        <= '0;
        count      <= '0;
      end
      if (do_accum) begin
        prev_phase <= phase_w;
        acc        <= acc_sum;
        count      <= count + 1'b1;
      end
      if (do_final) begin
        // prev_phase keeps running so the next window starts seamlessly.
        prev_phase  <= phase_w;
        acc         <= '0;
        count       <= '0;
        freq_word_q <= new_est;
        locked_q    <= have_est && within_tol;
        have_est    <= 1'b1;
      end
    end
  end

  assign bus.phase_out     = phase_w;
  assign bus.phase_valid   = pv_w;
  assign bus.freq_word_out = freq_word_q;
  assign bus.freq_valid    = freq_valid_q;
  assign bus.locked        = locked_q;
  assign state_dbg         = state;

endmodule

// File: tb/tb_nco_frequency_estimator.sv
// Bench for nco_frequency_estimator: ideal tones and corner vectors are
// compared against expectations computed from real-valued math.
module tb_nco_frequency_estimator;
  import nco_est_pkg::*;

  localparam int  SW  = 16;
  localparam int  PW  = 32;
  localparam int  STG = 16;
  localparam int  AL  = 8;
  localparam int  WIN = 1 << AL;
  localparam real PI  = 3.14159265358979323846;
  localparam longint PH_TOL = 64'd131072;
  localparam longint FQ_TOL = 64'h400;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  est_state_t state_dbg;
  int         cyc = 0;

  nco_frequency_estimator_if #(.SAMPLE_WIDTH(SW), .PHASE_WIDTH(PW)) bus ();

  nco_frequency_estimator #(
    .SAMPLE_WIDTH (SW),
    .PHASE_WIDTH  (PW),
    .CORDIC_STAGES(STG),
    .AVG_LOG2     (AL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .clear    (clear),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  // Compares modulo 2^32 so phase/frequency words wrap correctly.
  task automatic check(input string tag, input longint obs, input longint exp, input longint tol);
    logic [31:0] d;
    longint      ad;
    n_checks++;
    d  = 32'(obs - exp);
    ad = d[31] ? (64'd4294967296 - longint'(d)) : longint'(d);
    if (ad > tol) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h (tol 0x%0h) at cycle %0d", tag, obs, exp, tol, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [PW-1:0] exp_q[$];      // expected phase per sample
  int            exp_cyc_q[$];  // cycle it must appear in
  longint        exp_tol_q[$];
  int            got_cyc_q[$];  // observed freq_valid events
  logic [PW-1:0] got_word_q[$];
  logic          got_lock_q[$];

  logic [PW-1:0] mon_ph;
  int            mon_c;
  longint        mon_t;

  always @(negedge clk) begin
    if (bus.phase_valid) begin
      if (exp_q.size() == 0) begin
        check("phase_unexpected", 1, 0, 0);
      end else begin
        mon_ph = exp_q.pop_front();
        mon_c  = exp_cyc_q.pop_front();
        mon_t  = exp_tol_q.pop_front();
        check("phase_latency", cyc, mon_c, 0);
        check("phase_value", bus.phase_out, mon_ph, mon_t);
      end
    end
    if (bus.freq_valid) begin
      got_cyc_q.push_back(cyc);
      got_word_q.push_back(bus.freq_word_out);
      got_lock_q.push_back(bus.locked);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] turns_of(input real ang);
    real    t;
    longint l;
    t = ang / (2.0 * PI) * 4294967296.0;
    if (t < 0.0) t = t + 4294967296.0;
    l = longint'(t);
    return l[31:0];
  endfunction

  // Drives one valid sample this cycle and books its expected phase.
  task automatic send(input int s, input int c);
    bus.sine_in   = SW'(s);
    bus.cosine_in = SW'(c);
    bus.valid_in  = 1'b1;
    if (s == 0 && c == 0) begin
      exp_q.push_back('0);
      exp_tol_q.push_back(0);
    end else begin
      exp_q.push_back(turns_of($atan2(real'(s), real'(c))));
      exp_tol_q.push_back(PH_TOL);
    end
    exp_cyc_q.push_back(cyc + STG + 1);
  endtask

  task automatic quiet();
    bus.valid_in  = 1'b0;
    bus.sine_in   = '0;
    bus.cosine_in = '0;
  endtask

  // Tone run: one sample every `duty` cycles, phase advancing by `word` per
  // sample. Optional clear pulse at clr_t, optional enable drop at drop_t.
  task automatic run_scn(input string name, input logic [PW-1:0] word, input int duty,
                         input int n_cyc, input int clr_t, input int drop_t, input int drop_len);
    int            p_q[$];
    int            seg_s[$];
    int            seg_e[$];
    bit            seg_keep[$];
    int            exp_c[$];
    bit            exp_l[$];
    int            e, s, c, idx0, n;
    bit            has_prev;
    logic [PW-1:0] ph;
    real           a;

    enable = 1'b0;
    clear  = 1'b0;
    quiet();
    repeat (STG + 4) tick();
    got_cyc_q.delete();
    got_word_q.delete();
    got_lock_q.delete();

    ph = $urandom;
    e  = cyc;
    for (int t = 0; t < n_cyc; t++) begin
      enable = !(drop_t >= 0 && t >= drop_t && t < drop_t + drop_len);
      clear  = (t == clr_t);
      if (t % duty == 0) begin
        a = real'(ph) * 2.0 * PI / 4294967296.0;
        s = int'(30000.0 * $sin(a));
        c = int'(30000.0 * $cos(a));
        send(s, c);
        p_q.push_back(cyc + STG + 1);
        ph = ph + word;
      end else begin
        quiet();
      end
      if (clr_t >= 0 && t == clr_t + 1) begin
        @(negedge clk);
        check({name, "_locked_after_clear"}, bus.locked, 0, 0);
      end
      if (drop_t >= 0 && t == drop_t + drop_len - 1) begin
        @(negedge clk);
        check({name, "_idle_state"}, state_dbg, S_IDLE, 0);
        check({name, "_idle_hold_word"}, bus.freq_word_out, word, FQ_TOL);
        check({name, "_idle_hold_locked"}, bus.locked, 1, 0);
      end
      tick();
    end
    enable = 1'b0;
    clear  = 1'b0;
    quiet();
    repeat (STG + 4) tick();

    // Model: each run segment primes on its first phase output and then
    // yields an estimate on every WIN-th following phase output.
    seg_s.push_back(e + 1);
    seg_keep.push_back(1'b0);
    if (clr_t >= 0) begin
      seg_e.push_back(e + clr_t);
      seg_s.push_back(e + clr_t + 1);
      seg_keep.push_back(1'b1);
    end
    if (drop_t >= 0) begin
      seg_e.push_back(e + drop_t);
      seg_s.push_back(e + drop_t + drop_len + 1);
      seg_keep.push_back(1'b0);
    end
    seg_e.push_back(e + n_cyc);

    has_prev = 1'b0;
    for (int g = 0; g < seg_s.size(); g++) begin
      if (!seg_keep[g]) has_prev = 1'b0;
      idx0 = p_q.size();
      for (int j = p_q.size() - 1; j >= 0; j--) if (p_q[j] >= seg_s[g]) idx0 = j;
      for (int j = idx0 + WIN; j < p_q.size() && p_q[j] < seg_e[g]; j += WIN) begin
        exp_c.push_back(p_q[j] + 1);
        exp_l.push_back(has_prev);
        has_prev = 1'b1;
      end
    end

    check({name, "_num_estimates"}, got_cyc_q.size(), exp_c.size(), 0);
    n = (got_cyc_q.size() < exp_c.size()) ? got_cyc_q.size() : exp_c.size();
    for (int k = 0; k < n; k++) begin
      check({name, "_est_cycle"}, got_cyc_q[k], exp_c[k], 0);
      check({name, "_est_word"}, got_word_q[k], word, FQ_TOL);
      check({name, "_est_locked"}, got_lock_q[k], exp_l[k], 0);
    end
  endtask

  // ---------------- stimulus ----------------
  int pt_s[6] = '{-32768, 0, 30000, -30000,      0, 32767};
  int pt_c[6] = '{-32768, 0,     0,      0, -30000, 32767};

  initial begin
    int            amp, s, c, clr_t;
    logic [PW-1:0] w;
    real           a;

    quiet();
    // Reset with valid_in toggling: nothing may leak out.
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.valid_in  = (i % 2 == 0);
      bus.sine_in   = SW'($urandom);
      bus.cosine_in = SW'($urandom);
      @(negedge clk);
      check("rst_phase_valid", bus.phase_valid, 0, 0);
      check("rst_phase_out", bus.phase_out, 0, 0);
      check("rst_freq_valid", bus.freq_valid, 0, 0);
      check("rst_freq_word", bus.freq_word_out, 0, 0);
      check("rst_locked", bus.locked, 0, 0);
      check("rst_state", state_dbg, S_IDLE, 0);
    end
    tick();
    rst = 1'b0;
    quiet();
    repeat (STG + 4) tick();

    // Corner vectors and random-amplitude points (estimator left idle).
    got_cyc_q.delete();
    for (int i = 0; i < 6; i++) begin
      send(pt_s[i], pt_c[i]);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      amp = $urandom_range(16000, 32000);
      w   = $urandom;
      a   = real'(w) * 2.0 * PI / 4294967296.0;
      s   = int'(real'(amp) * $sin(a));
      c   = int'(real'(amp) * $cos(a));
      send(s, c);
      if ($urandom_range(0, 2) == 0) begin
        tick();
        quiet();
      end
      tick();
    end
    quiet();
    repeat (STG + 4) tick();
    check("points_no_estimate", got_cyc_q.size(), 0, 0);

    run_scn("pos",     32'h0010_0000, 1,  790, -1, -1, 0);
    run_scn("neg",     32'hFFF0_0000, 1,  790, -1, -1, 0);
    run_scn("nyquist", 32'h7FF0_0000, 1,  790, -1, -1, 0);
    // Clear either exactly on the third window's final sample or earlier.
    clr_t = 3 * 768 + STG + 1;
    if ($urandom_range(0, 1) == 1) clr_t = clr_t - 3 * $urandom_range(1, 200);
    run_scn("duty3",   32'h0020_0000, 3, 4000, clr_t, -1, 0);
    run_scn("endrop",  32'h0010_0000, 1, 1300, -1, 600, 50);

    check("phase_left_over", exp_q.size(), 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
